// File: rtl/mem_result_checker.sv
// Memory result checker: after a settle delay, reads a window of data memory and
// scores each word against a preloaded table of expected values and weights.
module mem_result_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 64,
    parameter int WAIT_W  = 16,
    parameter int SCORE_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic [$clog2(DEPTH):0]   num_checks_i,
    input  logic [WAIT_W-1:0]        wait_cycles_i,
    input  logic                     exp_wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] exp_wr_idx_i,
    input  logic [DATA_W-1:0]        exp_wr_data_i,
    input  logic [3:0]               exp_wr_weight_i,
    output logic                     mem_rd_en_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [DATA_W-1:0]        mem_rd_data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   pass_count_o,
    output logic [$clog2(DEPTH):0]   fail_count_o,
    output logic [SCORE_W-1:0]       score_o,
    output logic                     fail_valid_o,
    output logic [$clog2(DEPTH)-1:0] first_fail_idx_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CMP, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                fail_valid_q, fail_valid_d;
    logic [IDX_W-1:0]    first_fail_q, first_fail_d;

    logic [DATA_W-1:0]   exp_mem [DEPTH];
    logic [3:0]          wgt_mem [DEPTH];
    logic [SCORE_W:0]    score_sum;

    assign busy_o           = (state_q == S_WAIT) || (state_q == S_READ) || (state_q == S_CMP);
    assign done_o           = (state_q == S_DONE);
    assign mem_rd_en_o      = (state_q == S_READ);
    assign mem_addr_o       = base_q + ADDR_W'(idx_q);
    assign pass_count_o     = pass_q;
    assign fail_count_o     = fail_q;
    assign score_o          = score_q;
    assign fail_valid_o     = fail_valid_q;
    assign first_fail_idx_o = first_fail_q;

    // NOTE: the table has no reset so it maps onto plain RAM; its contents survive reset.
    always_ff @(posedge clk_i) begin
        if (exp_wr_en_i && !busy_o) begin
            exp_mem[exp_wr_idx_i] <= exp_wr_data_i;
            wgt_mem[exp_wr_idx_i] <= exp_wr_weight_i;
        end
    end

    // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        wait_d       = wait_q;
        wait_cnt_d   = wait_cnt_q;
        idx_d        = idx_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        score_d      = score_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        score_sum    = {1'b0, score_q} + (SCORE_W+1)'(wgt_mem[idx_q]);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d      = S_WAIT;
                    base_d       = base_addr_i;
                    num_d        = (num_checks_i > DEPTH_CNT) ? DEPTH_CNT : num_checks_i;
                    wait_d       = wait_cycles_i;
                    wait_cnt_d   = '0;
                    idx_d        = '0;
                    pass_d       = '0;
                    fail_d       = '0;
                    score_d      = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == wait_q) begin
                    state_d = (num_q == '0) ? S_DONE : S_READ;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_READ: state_d = S_CMP;
            S_CMP: begin
                // Read data returns exactly one cycle after the strobe, i.e. now.
                if (mem_rd_data_i == exp_mem[idx_q]) begin
                    pass_d  = pass_q + CNT_W'(1);
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                end else begin
                    fail_d = fail_q + CNT_W'(1);
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = idx_q;
                    end
                end
                if (CNT_W'(idx_q) + CNT_W'(1) == num_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            num_q        <= '0;
            wait_q       <= '0;
            wait_cnt_q   <= '0;
            idx_q        <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            score_q      <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            wait_q       <= wait_d;
            wait_cnt_q   <= wait_cnt_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            score_q      <= score_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end
endmodule

// File: tb/tb_mem_result_checker.sv
// Scoreboard bench for mem_result_checker: a run-level reference model predicts
// read addresses, timing and results; a negedge monitor compares what the DUT shows.
module tb_mem_result_checker;
    localparam int DEPTH = 64;

    typedef struct {
        int pass_n;
        int fail_n;
        int score;
        int score4;
        int fv;
        int ffi;
        int nreads;
        int wait_cyc;
        int done_lat;
        int start_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [6:0]  num_checks;
    logic [15:0] wait_cycles;
    logic        exp_wr_en;
    logic [5:0]  exp_wr_idx;
    logic [31:0] exp_wr_data;
    logic [3:0]  exp_wr_weight;

    logic        mem_rd_en, busy, done, fail_valid;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic [6:0]  pass_count, fail_count;
    logic [15:0] score;
    logic [5:0]  first_fail_idx;

    logic        mem_rd_en_s, busy_s, done_s, fail_valid_s;
    logic [7:0]  mem_addr_s;
    logic [31:0] mem_rd_data_s;
    logic [6:0]  pass_count_s, fail_count_s;
    logic [3:0]  score_s;
    logic [5:0]  first_fail_idx_s;

    logic [31:0] mem_model [256];
    logic [31:0] exp_model [DEPTH];
    logic [3:0]  wgt_model [DEPTH];

    exp_t        sb [$];
    int          exp_addr_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    mem_result_checker dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
        .num_checks_i(num_checks), .wait_cycles_i(wait_cycles), .exp_wr_en_i(exp_wr_en),
        .exp_wr_idx_i(exp_wr_idx), .exp_wr_data_i(exp_wr_data), .exp_wr_weight_i(exp_wr_weight),
        .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rd_data_i(mem_rd_data),
        .busy_o(busy), .done_o(done), .pass_count_o(pass_count), .fail_count_o(fail_count),
        .score_o(score), .fail_valid_o(fail_valid), .first_fail_idx_o(first_fail_idx)
    );

    mem_result_checker #(.SCORE_W(4)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
        .num_checks_i(num_checks), .wait_cycles_i(wait_cycles), .exp_wr_en_i(exp_wr_en),
        .exp_wr_idx_i(exp_wr_idx), .exp_wr_data_i(exp_wr_data), .exp_wr_weight_i(exp_wr_weight),
        .mem_rd_en_o(mem_rd_en_s), .mem_addr_o(mem_addr_s), .mem_rd_data_i(mem_rd_data_s),
        .busy_o(busy_s), .done_o(done_s), .pass_count_o(pass_count_s), .fail_count_o(fail_count_s),
        .score_o(score_s), .fail_valid_o(fail_valid_s), .first_fail_idx_o(first_fail_idx_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: answers one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        mem_rd_data   <= mem_rd_en   ? mem_model[mem_addr]   : $urandom;
        mem_rd_data_s <= mem_rd_en_s ? mem_model[mem_addr_s] : $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_run(input int base, input int num, input int wt);
        exp_t e;
        int   n;
        int   sum;
        e   = '{default: 0};
        n   = (num > DEPTH) ? DEPTH : num;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            if (mem_model[(base + i) % 256] === exp_model[i]) begin
                e.pass_n++;
                sum += int'(wgt_model[i]);
            end else begin
                e.fail_n++;
                if (e.fv == 0) begin
                    e.fv  = 1;
                    e.ffi = i;
                end
            end
        end
        e.score    = (sum > 65535) ? 65535 : sum;
        e.score4   = (sum > 15) ? 15 : sum;
        e.nreads   = n;
        e.wait_cyc = wt;
        e.done_lat = wt + 1 + 2 * n;
        return e;
    endfunction

    task automatic wr_entry(input int idx, input logic [31:0] data, input int w);
        exp_wr_en     = 1'b1;
        exp_wr_idx    = idx[5:0];
        exp_wr_data   = data;
        exp_wr_weight = w[3:0];
        exp_model[idx] = data;
        wgt_model[idx] = w[3:0];
        step();
        exp_wr_en = 1'b0;
    endtask

    task automatic start_run(input int base, input int num, input int wt, input bit do_wr = 1'b0,
                             input int widx = 0, input logic [31:0] wdata = '0, input int ww = 0);
        exp_t e;
        if (do_wr) begin
            exp_wr_en      = 1'b1;
            exp_wr_idx     = widx[5:0];
            exp_wr_data    = wdata;
            exp_wr_weight  = ww[3:0];
            exp_model[widx] = wdata;
            wgt_model[widx] = ww[3:0];
        end
        base_addr   = base[7:0];
        num_checks  = num[6:0];
        wait_cycles = wt[15:0];
        start       = 1'b1;
        e = model_run(base, num, wt);
        e.start_edge = cyc + 1;
        sb.push_back(e);
        for (int i = 0; i < e.nreads; i++) exp_addr_q.push_back((base + i) % 256);
        step();
        start     = 1'b0;
        exp_wr_en = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", done, 1);
        step();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_rd_en"}, mem_rd_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_pass"}, pass_count, 0);
        check({tag, "_fail"}, fail_count, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_fail_valid"}, fail_valid, 0);
        check({tag, "_first_fail"}, first_fail_idx, 0);
    endtask

    // Monitor: compares every read and every completed run against the scoreboard.
    int   run_reads = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) begin
            run_reads = 0;
            done_prev = 1'b0;
        end else begin
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_read", mem_rd_en, 0);
                end else begin
                    a = exp_addr_q.pop_front();
                    check("rd_addr", mem_addr, a);
                    if (run_reads == 0 && sb.size() > 0)
                        check("first_rd_latency", cyc - sb[0].start_edge, sb[0].wait_cyc + 1);
                    run_reads++;
                end
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_latency", cyc - e.start_edge, e.done_lat);
                    check("read_count", run_reads, e.nreads);
                    check("pass_count", pass_count, e.pass_n);
                    check("fail_count", fail_count, e.fail_n);
                    check("score", score, e.score);
                    check("fail_valid", fail_valid, e.fv);
                    if (e.fv != 0) check("first_fail_idx", first_fail_idx, e.ffi);
                    check("sat_done", done_s, 1);
                    check("sat_score", score_s, e.score4);
                end
                run_reads = 0;
            end
            done_prev = done;
        end
    end

    initial begin
        int k;
        int reads;
        int base;
        int num;
        int wt;
        int held_pass;

        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_checks = '0; wait_cycles = '0;
        exp_wr_en = 1'b0; exp_wr_idx = '0; exp_wr_data = '0; exp_wr_weight = '0;
        repeat (3) step();
        check_cleared("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < DEPTH; i++)
            wr_entry(i, ($urandom_range(0, 1) != 0) ? mem_model[i] : 32'($urandom), $urandom_range(0, 15));

        // Match run at base 11
        for (int i = 0; i < 4; i++) wr_entry(i, mem_model[11 + i], 2);
        start_run(11, 4, 0);
        wait_done(20);
        check("match_pass", pass_count, 4);
        check("match_fail", fail_count, 0);
        check("match_score", score, 8);
        check("match_fail_valid", fail_valid, 0);
        held_pass = int'(pass_count);
        repeat (3) step();
        check("done_held", done, 1);
        check("results_stable", pass_count, held_pass);

        // Mismatch run: entries 2 and 5 wrong
        for (int i = 0; i < 6; i++)
            wr_entry(i, (i == 2 || i == 5) ? ~mem_model[40 + i] : mem_model[40 + i], 5);
        start_run(40, 6, 1);
        wait_done(30);
        check("mismatch_pass", pass_count, 4);
        check("mismatch_fail", fail_count, 2);
        check("mismatch_score", score, 20);
        check("mismatch_first_fail", first_fail_idx, 2);

        // Wrap and settle
        start_run(8'hFE, 3, 10);
        wait_done(40);

        // Empty and clamped runs
        start_run(5, 0, 2);
        wait_done(20);
        check("empty_pass", pass_count, 0);
        check("empty_fail", fail_count, 0);
        start_run(200, DEPTH + 1, 0);
        wait_done(2 * DEPTH + 20);
        check("clamp_total", pass_count + fail_count, DEPTH);

        // Start and table write while busy are ignored
        for (int i = 0; i < 4; i++) wr_entry(i, mem_model[20 + i], 1);
        start_run(20, 4, 5);
        step();
        start = 1'b1; base_addr = 8'd0; num_checks = 7'd1; wait_cycles = 16'd0;
        exp_wr_en = 1'b1; exp_wr_idx = 6'd0; exp_wr_data = ~mem_model[20]; exp_wr_weight = 4'd9;
        step();
        start = 1'b0; exp_wr_en = 1'b0;
        wait_done(30);
        check("busy_ignore_pass", pass_count, 4);
        check("busy_ignore_score", score, 4);

        // Start with a simultaneous table write sees the new entry
        start_run(20, 4, 0, 1'b1, 1, ~mem_model[21], 3);
        wait_done(20);
        check("simul_wr_fail", fail_count, 1);
        check("simul_wr_first_fail", first_fail_idx, 1);

        // Saturation on the narrow-score instance
        for (int i = 0; i < 3; i++) wr_entry(i, mem_model[100 + i], 15);
        start_run(100, 3, 0);
        wait_done(20);
        check("sat_score_direct", score_s, 15);
        check("wide_score_direct", score, 45);

        // Reset during CMP abandons the run
        for (int i = 0; i < 4; i++) wr_entry(i, mem_model[30 + i], 3);
        start_run(30, 4, 0);
        k = 0; reads = 0;
        while (reads < 2 && k < 50) begin
            @(negedge clk);
            if (mem_rd_en) reads++;
            k++;
        end
        check("reset_test_reads_seen", reads, 2);
        step();
        check("pre_reset_pass", pass_count, 1);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        sb.delete();
        exp_addr_q.delete();
        step();
        check_cleared("midrun_reset");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("post_reset_idle", busy, 0);

        // Randomized runs; the table is untouched by reset
        for (int r = 0; r < 12; r++) begin
            base = $urandom_range(0, 255);
            num  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, DEPTH + 1) : $urandom_range(0, 8);
            wt   = $urandom_range(0, 4);
            if (r > 0) begin
                for (int j = 0; j < 4; j++) begin
                    k = $urandom_range(0, 7);
                    wr_entry(k, ($urandom_range(0, 1) != 0) ? mem_model[(base + k) % 256] : 32'($urandom),
                             $urandom_range(0, 15));
                end
            end
            start_run(base, num, wt);
            wait_done(wt + 2 * DEPTH + 20);
        end

        repeat (3) step();
        check("scoreboard_drained", sb.size(), 0);
        check("addr_queue_drained", exp_addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
